// File: rtl/control_status_register_unit_if.sv
// CSR access bus between the decoder (master) and the CSR unit (slave).
// Master drives the operation (enable, op, index, operand); slave returns
// the old CSR value and the illegal-access flag in the same cycle.
interface control_status_register_unit_if;
   logic        csr_enable;
   logic [1:0]  csr_op;
   logic [11:0] csr_index;
   logic [31:0] csr_write_data;
   logic [31:0] csr_read_data;
   logic        csr_illegal;

   modport master (
      output csr_enable, csr_op, csr_index, csr_write_data,
      input  csr_read_data, csr_illegal
   );

   modport slave (
      input  csr_enable, csr_op, csr_index, csr_write_data,
      output csr_read_data, csr_illegal
   );
endinterface

// File: rtl/control_status_register_unit.sv
// CSR unit: bank of approximation-control CSRs plus free-running
// mcycle/minstret counters with atomic RW/RS/RC access and illegal flagging.
//
// Ports:
//   clk           clock, all state updates on posedge
//   reset_n       asynchronous active-low reset, clears all state
//   csr_bus       slave side of the CSR access bus (op in, old value/illegal out)
//   instret_pulse one instruction retired this cycle
//   apx_csr_out   flat approximation registers, register i at [32i+31:32i]
//
// Optional feature: define CSR_COUNTER_INHIBIT_EN to add mcountinhibit (0x320)
// with CY (bit 0) and IR (bit 2) stopping the respective counter.
module control_status_register_unit #(
   parameter int          NUM_APX_CSR   = 3,
   parameter logic [11:0] APX_BASE      = 12'h800,
   parameter int          COUNTER_WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         reset_n,
   control_status_register_unit_if.slave csr_bus,
   input  logic                         instret_pulse,
   output logic [32*NUM_APX_CSR-1:0]    apx_csr_out
);

   localparam logic [11:0] IDX_MCYCLE    = 12'hB00;
   localparam logic [11:0] IDX_MCYCLEH   = 12'hB80;
   localparam logic [11:0] IDX_MINSTRET  = 12'hB02;
   localparam logic [11:0] IDX_MINSTRETH = 12'hB82;
   localparam logic [11:0] IDX_CYCLE     = 12'hC00;
   localparam logic [11:0] IDX_CYCLEH    = 12'hC80;
   localparam logic [11:0] IDX_INSTRET   = 12'hC02;
   localparam logic [11:0] IDX_INSTRETH  = 12'hC82;
`ifdef CSR_COUNTER_INHIBIT_EN
   localparam logic [11:0] IDX_MCOUNTINHIBIT = 12'h320;
`endif
   localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

   logic [31:0]              apx_q [NUM_APX_CSR];
   logic [COUNTER_WIDTH-1:0] mcycle_q;
   logic [COUNTER_WIDTH-1:0] minstret_q;
   logic [63:0]              mcycle_ext;
   logic [63:0]              minstret_ext;
   logic                     inhibit_cy;
   logic                     inhibit_ir;

   logic                     implemented;
   logic                     read_only;
   logic [31:0]              old_value;
   logic [NUM_APX_CSR-1:0]   apx_hit;
   logic [31:0]              new_value;
   logic                     effective_write;
   logic                     write_ok;

   // Zero-extend so high-half reads return 0 above COUNTER_WIDTH.
   assign mcycle_ext   = 64'(mcycle_q);
   assign minstret_ext = 64'(minstret_q);

   always_comb begin
      implemented = 1'b0;
      read_only   = 1'b0;
      old_value   = '0;
      apx_hit     = '0;
      for (int i = 0; i < NUM_APX_CSR; i++) begin
         if (csr_bus.csr_index == APX_BASE + 12'(i)) begin
            implemented = 1'b1;
            apx_hit[i]  = 1'b1;
            old_value   = apx_q[i];
         end
      end
      case (csr_bus.csr_index)
         IDX_MCYCLE:    begin implemented = 1'b1; old_value = mcycle_ext[31:0];    end
         IDX_MCYCLEH:   begin implemented = 1'b1; old_value = mcycle_ext[63:32];   end
         IDX_MINSTRET:  begin implemented = 1'b1; old_value = minstret_ext[31:0];  end
         IDX_MINSTRETH: begin implemented = 1'b1; old_value = minstret_ext[63:32]; end
         IDX_CYCLE:     begin implemented = 1'b1; read_only = 1'b1; old_value = mcycle_ext[31:0];    end
         IDX_CYCLEH:    begin implemented = 1'b1; read_only = 1'b1; old_value = mcycle_ext[63:32];   end
         IDX_INSTRET:   begin implemented = 1'b1; read_only = 1'b1; old_value = minstret_ext[31:0];  end
         IDX_INSTRETH:  begin implemented = 1'b1; read_only = 1'b1; old_value = minstret_ext[63:32]; end
`ifdef CSR_COUNTER_INHIBIT_EN
         IDX_MCOUNTINHIBIT: begin
            implemented = 1'b1;
            old_value   = {29'd0, inhibit_ir, 1'b0, inhibit_cy};
         end
`endif
         default: ;
      endcase
   end

   always_comb begin
      case (csr_bus.csr_op)
         2'b01:   new_value = csr_bus.csr_write_data;
         2'b10:   new_value = old_value | csr_bus.csr_write_data;
         2'b11:   new_value = old_value & ~csr_bus.csr_write_data;
         default: new_value = old_value;
      endcase
   end

   // RS/RC with a zero operand are pure reads, so they stay legal on aliases.
   assign effective_write = csr_bus.csr_enable && (csr_bus.csr_op != 2'b00) &&
                            ((csr_bus.csr_op == 2'b01) || (csr_bus.csr_write_data != 32'd0));
   assign csr_bus.csr_illegal = csr_bus.csr_enable &&
                                (!implemented || (effective_write && read_only));
   assign write_ok = effective_write && !csr_bus.csr_illegal;
   assign csr_bus.csr_read_data = (csr_bus.csr_enable && !csr_bus.csr_illegal) ? old_value : 32'd0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_APX_CSR; i++) apx_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_APX_CSR; i++) begin
            if (write_ok && apx_hit[i]) apx_q[i] <= new_value;
         end
      end
   end

   // A half write freezes the whole counter for that edge: no increment and
   // no carry into the unwritten half.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcycle_q   <= '0;
         minstret_q <= '0;
      end else begin
         if (write_ok && csr_bus.csr_index == IDX_MCYCLE)
            mcycle_q <= {mcycle_q[COUNTER_WIDTH-1:32], new_value};
         else if (write_ok && csr_bus.csr_index == IDX_MCYCLEH)
            mcycle_q <= {new_value[COUNTER_WIDTH-33:0], mcycle_q[31:0]};
         else if (!inhibit_cy)
            mcycle_q <= mcycle_q + CNT_ONE;

         if (write_ok && csr_bus.csr_index == IDX_MINSTRET)
            minstret_q <= {minstret_q[COUNTER_WIDTH-1:32], new_value};
         else if (write_ok && csr_bus.csr_index == IDX_MINSTRETH)
            minstret_q <= {new_value[COUNTER_WIDTH-33:0], minstret_q[31:0]};
         else if (instret_pulse && !inhibit_ir)
            minstret_q <= minstret_q + CNT_ONE;
      end
   end

`ifdef CSR_COUNTER_INHIBIT_EN
   logic inhibit_cy_q;
   logic inhibit_ir_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inhibit_cy_q <= 1'b0;
         inhibit_ir_q <= 1'b0;
      end else if (write_ok && csr_bus.csr_index == IDX_MCOUNTINHIBIT) begin
         inhibit_cy_q <= new_value[0];
         inhibit_ir_q <= new_value[2];
      end
   end

   assign inhibit_cy = inhibit_cy_q;
   assign inhibit_ir = inhibit_ir_q;
`else
   assign inhibit_cy = 1'b0;
   assign inhibit_ir = 1'b0;
`endif

   for (genvar g = 0; g < NUM_APX_CSR; g++) begin : g_apx_out
      assign apx_csr_out[32*g +: 32] = apx_q[g];
   end

endmodule

// File: tb/tb_control_status_register_unit.sv
// Scoreboard bench for control_status_register_unit: the stimulus process
// predicts each access from a behavioural CSR model and queues the expected
// response; a monitor on the falling edge compares whenever csr_enable is high.
module tb_control_status_register_unit;
   localparam int NUM = 3;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic instret_pulse = 1'b0;
   logic [32*NUM-1:0] apx_csr_out;

   control_status_register_unit_if bus ();

   control_status_register_unit #(
      .NUM_APX_CSR(NUM), .APX_BASE(12'h800), .COUNTER_WIDTH(64)
   ) dut (
      .clk(clk), .reset_n(reset_n), .csr_bus(bus),
      .instret_pulse(instret_pulse), .apx_csr_out(apx_csr_out)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0]       rdata;
      logic              illegal;
      logic [32*NUM-1:0] apx;
   } exp_t;

   exp_t exp_q[$];
   int n_total = 0;
   int n_pass  = 0;

   logic [31:0] m_apx [NUM];
   logic [63:0] m_cyc;
   logic [63:0] m_ins;
   logic [31:0] m_inh;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NUM; i++) m_apx[i] = '0;
      m_cyc = '0;
      m_ins = '0;
      m_inh = '0;
   endfunction

   function automatic logic [32*NUM-1:0] model_flat();
      logic [32*NUM-1:0] f;
      for (int i = 0; i < NUM; i++) f[32*i +: 32] = m_apx[i];
      return f;
   endfunction

   function automatic void model_lookup(input logic [11:0] idx, output bit impl,
                                        output bit ro, output logic [31:0] val);
      int k;
      impl = 0; ro = 0; val = '0;
      k = int'(idx) - 'h800;
      if (k >= 0 && k < NUM) begin impl = 1; val = m_apx[k]; end
      case (idx)
         12'hB00: begin impl = 1; val = m_cyc[31:0];  end
         12'hB80: begin impl = 1; val = m_cyc[63:32]; end
         12'hB02: begin impl = 1; val = m_ins[31:0];  end
         12'hB82: begin impl = 1; val = m_ins[63:32]; end
         12'hC00: begin impl = 1; ro = 1; val = m_cyc[31:0];  end
         12'hC80: begin impl = 1; ro = 1; val = m_cyc[63:32]; end
         12'hC02: begin impl = 1; ro = 1; val = m_ins[31:0];  end
         12'hC82: begin impl = 1; ro = 1; val = m_ins[63:32]; end
`ifdef CSR_COUNTER_INHIBIT_EN
         12'h320: begin impl = 1; val = m_inh; end
`endif
         default: ;
      endcase
   endfunction

   // One clock of stimulus. chk[0] adds a directed read-data check, chk[1]
   // a directed illegal-flag check, both against constants from the caller.
   task automatic cycle(input bit en, input logic [1:0] op, input logic [11:0] idx,
                        input logic [31:0] wd, input bit ip, input bit [1:0] chk,
                        input logic [31:0] exp_rd, input bit exp_ill, input string name);
      bit impl, ro, eff, ill, cyc_w, ins_w;
      logic [31:0] old, nv;
      exp_t e;
      int k;
      bus.csr_enable     = en;
      bus.csr_op         = op;
      bus.csr_index      = idx;
      bus.csr_write_data = wd;
      instret_pulse      = ip;
      model_lookup(idx, impl, ro, old);
      eff = en && op != 2'b00 && (op == 2'b01 || wd != 32'd0);
      ill = en && (!impl || (eff && ro));
      e.rdata   = (en && !ill) ? old : 32'd0;
      e.illegal = ill;
      e.apx     = model_flat();
      if (en) exp_q.push_back(e);
      @(negedge clk);
      if (chk[0]) check({name, "_rdata"}, 128'(bus.csr_read_data), 128'(exp_rd));
      if (chk[1]) check({name, "_illegal"}, 128'(bus.csr_illegal), 128'(exp_ill));
      @(posedge clk);
      if (!reset_n) model_reset();
      else begin
         cyc_w = 0; ins_w = 0;
         if (eff && !ill) begin
            case (op)
               2'b01:   nv = wd;
               2'b10:   nv = old | wd;
               default: nv = old & ~wd;
            endcase
            k = int'(idx) - 'h800;
            if (k >= 0 && k < NUM) m_apx[k] = nv;
            case (idx)
               12'hB00: begin m_cyc[31:0]  = nv; cyc_w = 1; end
               12'hB80: begin m_cyc[63:32] = nv; cyc_w = 1; end
               12'hB02: begin m_ins[31:0]  = nv; ins_w = 1; end
               12'hB82: begin m_ins[63:32] = nv; ins_w = 1; end
               12'h320: m_inh = nv & 32'h5;
               default: ;
            endcase
         end
         if (!cyc_w && !m_inh[0]) m_cyc = m_cyc + 64'd1;
         if (!ins_w && ip && !m_inh[2]) m_ins = m_ins + 64'd1;
      end
      #1;
   endtask

   always @(negedge clk) begin
      if (bus.csr_enable === 1'b1) begin
         if (exp_q.size() == 0) check("sb_underflow", 128'(1), 128'(0));
         else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_rdata", 128'(bus.csr_read_data), 128'(e.rdata));
            check("sb_illegal", 128'(bus.csr_illegal), 128'(e.illegal));
            check("sb_apx_out", 128'(apx_csr_out), 128'(e.apx));
         end
      end
   end

   logic [11:0] idx_tbl [14] = '{12'h800, 12'h801, 12'h802, 12'h803, 12'h7FF,
                                12'hB00, 12'hB80, 12'hB02, 12'hB82,
                                12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'h320};

   task automatic random_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         logic [31:0] wd;
         int sel;
         sel = int'($urandom_range(0, 7));
         if (sel < 2)       wd = 32'd0;
         else if (sel == 2) wd = 32'hFFFF_FFFF;
         else               wd = $urandom;
         cycle($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)),
               idx_tbl[$urandom_range(0, 13)], wd, 1'($urandom_range(0, 1)),
               2'b00, 32'd0, 1'b0, "rnd");
      end
   endtask

   initial begin
      bus.csr_enable     = 1'b0;
      bus.csr_op         = 2'b00;
      bus.csr_index      = 12'h000;
      bus.csr_write_data = 32'd0;
      model_reset();
      #1;
      check("reset_apx_out", 128'(apx_csr_out), 128'(0));
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;

      cycle(1, 2'b01, 12'h800, 32'hA5, 0, 2'b11, 32'h0, 0, "rw800_old");
      check("apx0_after_write", 128'(apx_csr_out[31:0]), 128'(32'hA5));
      cycle(1, 2'b00, 12'h800, 32'h0, 0, 2'b11, 32'hA5, 0, "rd800");
      cycle(1, 2'b10, 12'h801, 32'hF0, 0, 2'b11, 32'h0, 0, "rs801");
      cycle(1, 2'b11, 12'h801, 32'h30, 0, 2'b11, 32'hF0, 0, "rc801");
      cycle(1, 2'b00, 12'h801, 32'h0, 0, 2'b11, 32'hC0, 0, "rd801");

      cycle(1, 2'b01, 12'hB00, 32'hFFFF_FFFF, 0, 2'b10, 32'h0, 0, "rw_mcycle");
      cycle(1, 2'b00, 12'hB00, 32'h0, 0, 2'b11, 32'hFFFF_FFFF, 0, "rd_mcycle");
      cycle(1, 2'b00, 12'hB80, 32'h0, 0, 2'b11, 32'h1, 0, "rd_mcycleh");

      cycle(0, 2'b00, 12'h000, 32'h0, 1, 2'b00, 32'h0, 0, "ip1");
      cycle(0, 2'b00, 12'h000, 32'h0, 1, 2'b00, 32'h0, 0, "ip2");
      cycle(1, 2'b01, 12'hB02, 32'h10, 1, 2'b10, 32'h0, 0, "rw_minstret");
      cycle(0, 2'b00, 12'h000, 32'h0, 1, 2'b00, 32'h0, 0, "ip4");
      cycle(0, 2'b00, 12'h000, 32'h0, 1, 2'b00, 32'h0, 0, "ip5");
      cycle(1, 2'b00, 12'hB02, 32'h0, 0, 2'b11, 32'h12, 0, "rd_minstret");

      cycle(1, 2'b01, 12'hC00, 32'h1, 0, 2'b11, 32'h0, 1, "rw_cycle_ro");
      cycle(1, 2'b10, 12'hC00, 32'h0, 0, 2'b10, 32'h0, 0, "rs0_cycle");
      cycle(1, 2'b00, 12'h7FF, 32'h0, 0, 2'b11, 32'h0, 1, "unimpl_7ff");

`ifdef CSR_COUNTER_INHIBIT_EN
      cycle(1, 2'b01, 12'h320, 32'h1, 0, 2'b11, 32'h0, 0, "rw_inhibit");
      for (int i = 0; i < 10; i++)
         cycle(1, 2'b00, 12'hB00, 32'h0, 1, 2'b00, 32'h0, 0, "inh_run");
      cycle(1, 2'b00, 12'hB02, 32'h0, 0, 2'b00, 32'h0, 0, "inh_minstret");
      cycle(1, 2'b01, 12'h320, 32'hFFFF_FFFF, 0, 2'b11, 32'h1, 0, "rw_inhibit_all");
      cycle(1, 2'b00, 12'h320, 32'h0, 0, 2'b11, 32'h5, 0, "rd_inhibit");
      cycle(1, 2'b01, 12'h320, 32'h0, 0, 2'b11, 32'h5, 0, "clr_inhibit");
`else
      cycle(1, 2'b01, 12'h320, 32'h1, 0, 2'b11, 32'h0, 1, "inhibit_absent");
`endif

      random_cycles(500);

      cycle(1, 2'b01, 12'h800, 32'h5A, 0, 2'b00, 32'h0, 0, "pre_reset_wr");
      bus.csr_enable = 1'b0;
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check("midreset_apx_out", 128'(apx_csr_out), 128'(0));
      cycle(1, 2'b00, 12'hB00, 32'h0, 0, 2'b11, 32'h0, 0, "in_reset_mcycle");
      reset_n = 1'b1;
      cycle(1, 2'b00, 12'hB00, 32'h0, 0, 2'b11, 32'h0, 0, "first_after_reset");
      cycle(1, 2'b00, 12'hB00, 32'h0, 0, 2'b11, 32'h1, 0, "second_after_reset");

      random_cycles(200);

      bus.csr_enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("sb_drained", 128'(exp_q.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
